// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - CPU base types and shadow-pipeline stage metadata types
package cpu_types_pkg;
    typedef logic [5:0] opcode_t;
    typedef logic [4:0] regbits_t;

    localparam opcode_t RTYPE = 6'h00;
    localparam opcode_t ADDI  = 6'h08;
    localparam opcode_t LW    = 6'h23;
    localparam opcode_t SW    = 6'h2B;
    localparam opcode_t HALT  = 6'h3F;
endpackage

package diaosi_types_pkg;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic     valid;
        opcode_t  opcode;
        regbits_t rs;
        regbits_t rt;
        regbits_t wsel;
        logic     regwen;
        logic     dren;
        logic     dwen;
    } stage_meta_t;

    localparam int          STAGES      = 4;
    localparam stage_meta_t META_BUBBLE = '0;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard-unit control, fetch metadata and status bundle
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    import cpu_types_pkg::*;

    logic             pc_en;
    logic             pipe1_en;
    logic             pipe2_en;
    logic             pipe3_en;
    logic             pipe4_en;
    logic             flushed1;
    logic             flushed2;
    logic             flushed3;
    logic             ihit;
    logic             dhit;
    opcode_t          if_opcode;
    regbits_t         if_rs;
    regbits_t         if_rt;
    regbits_t         if_wsel;
    logic             if_regwen;
    logic             if_dren;
    logic             if_dwen;
    regbits_t         rsel1;
    regbits_t         rsel2;
    regbits_t         wsel;
    opcode_t          opcode;
    logic             dmemREN;
    logic             dmemWEN;
    logic             wb_regwen;
    regbits_t         wb_wsel;
    logic             halt;
    logic [3:0]       stage_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en,
        output flushed1, flushed2, flushed3, ihit, dhit,
        output if_opcode, if_rs, if_rt, if_wsel, if_regwen, if_dren, if_dwen,
        input  rsel1, rsel2, wsel, opcode, dmemREN, dmemWEN,
        input  wb_regwen, wb_wsel, halt, stage_valid, stall_cnt, flush_cnt
    );

    modport slave (
        input  pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en,
        input  flushed1, flushed2, flushed3, ihit, dhit,
        input  if_opcode, if_rs, if_rt, if_wsel, if_regwen, if_dren, if_dwen,
        output rsel1, rsel2, wsel, opcode, dmemREN, dmemWEN,
        output wb_regwen, wb_wsel, halt, stage_valid, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl_meta_reg.sv
// rtl/pipeline_ctrl_meta_reg.sv - single stage latch, flush beats enable beats hold
module pipe_meta_reg
    import diaosi_types_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_flush,
    input  logic        i_en,
    input  stage_meta_t i_d,
    output stage_meta_t o_q
);
    stage_meta_t r_q;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_q <= META_BUBBLE;
        end else if (i_flush) begin
            r_q <= META_BUBBLE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - shadow control pipeline, hazard-unit feeds, dmem handshake, halt, perf counters
module pipeline_ctrl
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic           CLK,
    input  logic           nRST,
    pipeline_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_INC = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_meta_t         w_d [STAGES];
    stage_meta_t         w_q [STAGES];
    logic [STAGES-1:0]   w_flush;
    logic [STAGES-1:0]   w_en;
    logic                w_halt_now;
    logic                w_halt;
    logic                w_req;
    logic                w_any_flush;
    logic                r_halt;
    logic                r_served;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    // HALT freezes the pipe the cycle it lands in MEM/WB, so it stays visible there.
    assign w_halt_now  = w_q[3].valid && (w_q[3].opcode == HALT);
    assign w_halt      = r_halt || w_halt_now;
    assign w_any_flush = bus.flushed1 || bus.flushed2 || bus.flushed3;

    assign w_flush = {1'b0, bus.flushed3, bus.flushed2, bus.flushed1} & {STAGES{!w_halt}};
    assign w_en    = {bus.pipe4_en, bus.pipe3_en, bus.pipe2_en, bus.pipe1_en} & {STAGES{!w_halt}};

    assign w_d[0] = bus.ihit ? {1'b1, bus.if_opcode, bus.if_rs, bus.if_rt, bus.if_wsel,
                                bus.if_regwen, bus.if_dren, bus.if_dwen}
                             : META_BUBBLE;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g > 0) begin : g_link
            assign w_d[g] = w_q[g-1];
        end
        pipe_meta_reg u_reg (
            .i_clk   (CLK),
            .i_nrst  (nRST),
            .i_flush (w_flush[g]),
            .i_en    (w_en[g]),
            .i_d     (w_d[g]),
            .o_q     (w_q[g])
        );
    end

    assign w_req = w_q[2].valid && (w_q[2].dren || w_q[2].dwen) && !r_served && !w_halt;

    // served marks the current EX/MEM access as done; new or flushed content rearms it.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_halt      <= 1'b0;
            r_served    <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_halt <= w_halt;
            if (!w_halt) begin
                if (bus.flushed3 || bus.pipe3_en) begin
                    r_served <= 1'b0;
                end else if (bus.dhit && w_req) begin
                    r_served <= 1'b1;
                end
                if (!bus.pc_en && (r_stall_cnt != '1)) begin
                    r_stall_cnt <= r_stall_cnt + CNT_INC;
                end
                if (w_any_flush && (r_flush_cnt != '1)) begin
                    r_flush_cnt <= r_flush_cnt + CNT_INC;
                end
            end
        end
    end

    assign bus.rsel1       = (nRST && w_q[0].valid) ? w_q[0].rs : '0;
    assign bus.rsel2       = (nRST && w_q[0].valid) ? w_q[0].rt : '0;
    assign bus.wsel        = (nRST && w_q[1].valid && w_q[1].regwen) ? w_q[1].wsel : '0;
    assign bus.opcode      = (nRST && w_q[1].valid) ? w_q[1].opcode : RTYPE;
    assign bus.dmemREN     = nRST && w_req && w_q[2].dren;
    assign bus.dmemWEN     = nRST && w_req && w_q[2].dwen;
    assign bus.wb_regwen   = w_q[3].valid && w_q[3].regwen;
    assign bus.wb_wsel     = w_q[3].wsel;
    assign bus.halt        = w_halt;
    assign bus.stage_valid = nRST ? {w_q[3].valid, w_q[2].valid, w_q[1].valid, w_q[0].valid} : 4'b0000;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed and randomized bench for pipeline_ctrl against a stage-array reference model
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    pipeline_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       v;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] ws;
        logic       rw;
        logic       dr;
        logic       dw;
    } meta_m_t;

    meta_m_t m [4];
    logic    m_served;
    logic    m_halt;
    int      m_stall;
    int      m_flush;
    int      n_tests = 0;
    int      n_fail  = 0;

    function automatic meta_m_t bubble();
        meta_m_t b;
        b.v = 0; b.op = 0; b.rs = 0; b.rt = 0; b.ws = 0; b.rw = 0; b.dr = 0; b.dw = 0;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: an array of stages shifted by the enables, evaluated on the pre-edge state.
    task automatic model_update();
        meta_m_t old [4];
        meta_m_t fetched;
        logic    halt_now;
        logic    req;
        old      = m;
        halt_now = m_halt || (m[3].v && m[3].op == HALT);
        req      = m[2].v && (m[2].dr || m[2].dw) && !m_served && !halt_now;
        fetched  = bubble();
        if (bus.ihit) begin
            fetched.v  = 1; fetched.op = bus.if_opcode; fetched.rs = bus.if_rs; fetched.rt = bus.if_rt;
            fetched.ws = bus.if_wsel; fetched.rw = bus.if_regwen; fetched.dr = bus.if_dren; fetched.dw = bus.if_dwen;
        end
        if (!nRST) begin
            for (int i = 0; i < 4; i++) m[i] = bubble();
            m_served = 0; m_halt = 0; m_stall = 0; m_flush = 0;
        end else if (halt_now) begin
            m_halt = 1;
        end else begin
            if (bus.pipe4_en) m[3] = old[2];
            if (bus.flushed3) m[2] = bubble(); else if (bus.pipe3_en) m[2] = old[1];
            if (bus.flushed2) m[1] = bubble(); else if (bus.pipe2_en) m[1] = old[0];
            if (bus.flushed1) m[0] = bubble(); else if (bus.pipe1_en) m[0] = fetched;
            if (bus.flushed3 || bus.pipe3_en) m_served = 0;
            else if (bus.dhit && req)         m_served = 1;
            if (!bus.pc_en && m_stall < SAT) m_stall++;
            if ((bus.flushed1 || bus.flushed2 || bus.flushed3) && m_flush < SAT) m_flush++;
        end
    endtask

    task automatic check_all();
        logic hn;
        logic rq;
        hn = m_halt || (m[3].v && m[3].op == HALT);
        rq = nRST && m[2].v && !m_served && !hn;
        chk("rsel1",     bus.rsel1,     (nRST && m[0].v) ? m[0].rs : 5'd0);
        chk("rsel2",     bus.rsel2,     (nRST && m[0].v) ? m[0].rt : 5'd0);
        chk("wsel",      bus.wsel,      (nRST && m[1].v && m[1].rw) ? m[1].ws : 5'd0);
        chk("opcode",    bus.opcode,    (nRST && m[1].v) ? m[1].op : 6'd0);
        chk("dmemREN",   bus.dmemREN,   rq && m[2].dr);
        chk("dmemWEN",   bus.dmemWEN,   rq && m[2].dw);
        chk("wb_regwen", bus.wb_regwen, m[3].v && m[3].rw);
        chk("wb_wsel",   bus.wb_wsel,   m[3].ws);
        chk("halt",      bus.halt,      hn);
        chk("stage_valid", bus.stage_valid, nRST ? {m[3].v, m[2].v, m[1].v, m[0].v} : 4'b0);
        chk("stall_cnt", bus.stall_cnt, m_stall);
        chk("flush_cnt", bus.flush_cnt, m_flush);
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
        check_all();
    endtask

    task automatic set_en(input logic pc, p1, p2, p3, p4);
        bus.pc_en = pc; bus.pipe1_en = p1; bus.pipe2_en = p2; bus.pipe3_en = p3; bus.pipe4_en = p4;
    endtask

    task automatic set_fl(input logic f1, f2, f3);
        bus.flushed1 = f1; bus.flushed2 = f2; bus.flushed3 = f3;
    endtask

    task automatic fetch(input logic [5:0] op, input logic [4:0] rs, rt, ws, input logic rw, dr, dw);
        bus.if_opcode = op; bus.if_rs = rs; bus.if_rt = rt; bus.if_wsel = ws;
        bus.if_regwen = rw; bus.if_dren = dr; bus.if_dwen = dw;
    endtask

    task automatic do_reset();
        nRST = 0;
        step();
        nRST = 1;
    endtask

    task automatic mem_test(input logic st);
        do_reset();
        set_en(1, 1, 1, 1, 1); set_fl(0, 0, 0); bus.ihit = 1; bus.dhit = 0;
        fetch(st ? SW : LW, 5'd1, 5'd2, st ? 5'd0 : 5'd6, !st, !st, st);
        step();
        fetch(RTYPE, 0, 0, 0, 0, 0, 0);
        step();
        step();
        set_en(0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            chk(st ? "dmem_wen_held" : "dmem_ren_held", st ? bus.dmemWEN : bus.dmemREN, 1'b1);
            chk(st ? "dmem_ren_idle" : "dmem_wen_idle", st ? bus.dmemREN : bus.dmemWEN, 1'b0);
            bus.dhit = (k == 3);
            step();
        end
        chk("dmem_drop", st ? bus.dmemWEN : bus.dmemREN, 1'b0);
        bus.dhit = 0;
        step();
        chk("dmem_stay_low", st ? bus.dmemWEN : bus.dmemREN, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m[i] = bubble();
        m_served = 0; m_halt = 0; m_stall = 0; m_flush = 0;
        set_en(0, 0, 0, 0, 0); set_fl(0, 0, 0); bus.ihit = 0; bus.dhit = 0;
        fetch(RTYPE, 0, 0, 0, 0, 0, 0);

        nRST = 0;
        step();
        step();
        chk("reset_halt", bus.halt, 1'b0);

        // flow: lw $5 followed by three valid fetches
        nRST = 1;
        set_en(1, 1, 1, 1, 1); bus.ihit = 1;
        fetch(LW, 5'd1, 5'd2, 5'd5, 1, 1, 0);
        step();
        chk("flow_sv1", bus.stage_valid, 4'b0001);
        fetch(RTYPE, 0, 0, 0, 0, 0, 0);
        step();
        chk("flow_sv2", bus.stage_valid, 4'b0011);
        chk("flow_wsel", bus.wsel, 5'd5);
        chk("flow_op", bus.opcode, LW);
        fetch(ADDI, 5'd4, 5'd0, 5'd10, 1, 0, 0);
        step();
        chk("flow_sv3", bus.stage_valid, 4'b0111);
        fetch(RTYPE, 5'd7, 5'd8, 5'd9, 1, 0, 0);
        step();
        chk("flow_sv4", bus.stage_valid, 4'b1111);

        // load-use stall
        set_en(0, 0, 0, 1, 1); set_fl(0, 1, 0);
        fetch(RTYPE, 5'd3, 5'd3, 5'd3, 1, 0, 0);
        step();
        chk("lu_wsel", bus.wsel, 5'd0);
        chk("lu_op", bus.opcode, 6'd0);
        chk("lu_rsel1", bus.rsel1, 5'd7);
        chk("lu_rsel2", bus.rsel2, 5'd8);
        chk("lu_stall", bus.stall_cnt, 4'd1);
        chk("lu_flush", bus.flush_cnt, 4'd1);
        set_fl(0, 0, 0);

        mem_test(0);
        mem_test(1);

        // flush beats enable
        set_en(1, 1, 1, 1, 1); set_fl(1, 0, 0); bus.ihit = 1;
        fetch(RTYPE, 5'd4, 5'd6, 5'd1, 1, 0, 0);
        step();
        chk("fl_valid0", bus.stage_valid[0], 1'b0);
        chk("fl_rsel1", bus.rsel1, 5'd0);
        chk("fl_rsel2", bus.rsel2, 5'd0);
        set_fl(0, 0, 0);

        // halt freezes everything until reset
        do_reset();
        set_en(1, 1, 1, 1, 1); bus.ihit = 1;
        fetch(HALT, 0, 0, 0, 0, 0, 0);
        step();
        fetch(RTYPE, 5'd1, 5'd1, 5'd1, 1, 0, 0);
        step();
        step();
        chk("halt_early", bus.halt, 1'b0);
        step();
        chk("halt_set", bus.halt, 1'b1);
        for (int k = 0; k < 6; k++) begin
            set_en($urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2);
            set_fl($urandom % 2, $urandom % 2, $urandom % 2);
            bus.dhit = $urandom % 2;
            step();
            chk("halt_sv", bus.stage_valid, 4'b1111);
            chk("halt_hold", bus.halt, 1'b1);
            chk("halt_stall", bus.stall_cnt, 4'd0);
            chk("halt_flush", bus.flush_cnt, 4'd0);
        end
        set_fl(0, 0, 0); bus.dhit = 0;
        nRST = 0;
        step();
        chk("halt_clr", bus.halt, 1'b0);
        nRST = 1;

        // stall counter saturation
        set_en(0, 1, 1, 1, 1);
        fetch(RTYPE, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 15 || k == 20) chk("sat_stall", bus.stall_cnt, 4'd15);
        end

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            logic [5:0] op;
            int r;
            r  = $urandom % 40;
            op = (r == 0) ? HALT : (r < 12) ? LW : (r < 22) ? SW : (r < 30) ? ADDI : RTYPE;
            nRST = ($urandom % 50) != 0;
            set_en(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
                   ($urandom % 4) != 0, ($urandom % 4) != 0);
            set_fl(($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 8) == 0);
            bus.ihit = ($urandom % 4) != 0;
            bus.dhit = ($urandom % 3) == 0;
            fetch(op, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), op == LW, op == SW);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
